mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage, sits directly downstream of EX.
//
// Registers the EX-to-MEM bus under stall control. For loads it waits for a
// variable-latency data SRAM response, holding the pipeline through
// stallreq_for_mem until the data arrives, then aligns and extends it.
//
// Ports:
//   clk               clock
//   resetn            asynchronous active-low reset
//   stall             per-stage stall vector; bit 3 holds EX/MEM, bit 4 MEM/WB
//   ex_to_mem_bus     {mem_op[80:76], pc[75:44], data_ram_en[43],
//                      data_ram_wen[42:39], sel_rf_res[38], rf_we[37],
//                      rf_waddr[36:32], ex_result[31:0]}
//   data_sram_rdata   SRAM read data
//   data_sram_rvalid  one-cycle pulse, rdata valid in that cycle
//   mem_to_wb_bus     {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
//   mem_to_rf_bus     {rf_we, rf_waddr, rf_wdata} forwarding path to ID
//   stallreq_for_mem  asks the stall controller to freeze the pipeline
//
// SRAM response handshake: data_sram_rvalid is a single-cycle pulse with no
// back-pressure. It is accepted only while the load in MEM is still waiting;
// a pulse at any other time (no load, data already captured, stale response
// after reset) is dropped.
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int EX_TO_MEM_WD = 81,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_W      = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [STALL_W-1:0]      stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_rf_bus,
  output logic                    stallreq_for_mem
);

  // Load FSM: state of the instruction currently held in the EX/MEM register.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no load in the register
    S_WAIT = 2'd1,  // load present, data not yet returned
    S_HAVE = 2'd2   // load data captured in rbuf
  } state_t;

  state_t                  state;
  logic [31:0]             rbuf;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_r;

  // Stall decode: bubble when EX/MEM is held but MEM/WB advances.
  logic reg_bubble;
  logic reg_load;
  assign reg_bubble = stall[3] & ~stall[4];
  assign reg_load   = ~stall[3];

  // Incoming instruction is a load (decides the FSM entry state).
  logic in_is_load;
  assign in_is_load = ex_to_mem_bus[43] & (|ex_to_mem_bus[80:76]) &
                      (ex_to_mem_bus[42:39] == 4'b0000);

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_to_mem_r <= '0;
    end else if (reg_bubble) begin
      ex_to_mem_r <= '0;
    end else if (reg_load) begin
      ex_to_mem_r <= ex_to_mem_bus;
    end
  end

  // Load FSM and response buffer. A new instruction entering the register
  // always restarts the FSM; a response is captured only while holding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      rbuf  <= 32'h0;
    end else if (reg_bubble) begin
      state <= S_IDLE;
    end else if (reg_load) begin
      state <= in_is_load ? S_WAIT : S_IDLE;
    end else begin
      case (state)
        S_WAIT: begin
          if (data_sram_rvalid) begin
            state <= S_HAVE;
            rbuf  <= data_sram_rdata;
          end
        end
        S_HAVE:  state <= S_HAVE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Field decode of the registered bus.
  logic [4:0]  mem_op;
  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic        is_load;

  assign mem_op       = ex_to_mem_r[80:76];
  assign pc           = ex_to_mem_r[75:44];
  assign data_ram_en  = ex_to_mem_r[43];
  assign data_ram_wen = ex_to_mem_r[42:39];
  assign rf_we        = ex_to_mem_r[37];
  assign rf_waddr     = ex_to_mem_r[36:32];
  assign ex_result    = ex_to_mem_r[31:0];
  assign is_load      = data_ram_en & (|mem_op) & (data_ram_wen == 4'b0000);

  // sel_rf_res is carried on the bus but plays no role in this stage;
  // stall bits other than 3 and 4 belong to other stages.
  logic unused_bits;
  assign unused_bits = ^{ex_to_mem_r[38], stall[2:0], stall[STALL_W-1:5]};

  // Source word: live SRAM data only in the cycle it is accepted, otherwise
  // the buffered copy, so stray pulses in HAVE cannot disturb the output.
  logic        take_live;
  logic [31:0] src_word;
  assign take_live = (state == S_WAIT) & data_sram_rvalid;
  assign src_word  = take_live ? data_sram_rdata : rbuf;

  // Alignment and extension. mem_op = {lb, lbu, lh, lhu, lw}.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  always_comb begin
    sel_byte = 8'h00;
    case (ex_result[1:0])
      2'd0:    sel_byte = src_word[7:0];
      2'd1:    sel_byte = src_word[15:8];
      2'd2:    sel_byte = src_word[23:16];
      default: sel_byte = src_word[31:24];
    endcase
  end

  assign sel_half = ex_result[1] ? src_word[31:16] : src_word[15:0];

  always_comb begin
    load_data = 32'h0;
    if (mem_op[4]) begin
      load_data = {{24{sel_byte[7]}}, sel_byte};
    end else if (mem_op[3]) begin
      load_data = {24'h0, sel_byte};
    end else if (mem_op[2]) begin
      load_data = {{16{sel_half[15]}}, sel_half};
    end else if (mem_op[1]) begin
      load_data = {16'h0, sel_half};
    end else if (mem_op[0]) begin
      load_data = src_word;
    end
  end

  logic [31:0] rf_wdata;
  assign rf_wdata = is_load ? load_data : ex_result;

  assign stallreq_for_mem = (state == S_WAIT) & ~data_sram_rvalid;
  assign mem_to_wb_bus    = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_rf_bus    = {rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// A behavioural model tracks which instruction sits in MEM and whether its
// load data has arrived; a compare process checks every output on every
// falling edge. Directed tasks add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [4:0] OP_LB  = 5'b10000;
  localparam logic [4:0] OP_LBU = 5'b01000;
  localparam logic [4:0] OP_LH  = 5'b00100;
  localparam logic [4:0] OP_LHU = 5'b00010;
  localparam logic [4:0] OP_LW  = 5'b00001;

  logic        clk;
  logic        resetn;
  logic [5:0]  stall;
  logic [80:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        stallreq_for_mem;

  int n_cmp;
  int n_err;
  bit chk_en;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .stall            (stall),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_rf_bus    (mem_to_rf_bus),
    .stallreq_for_mem (stallreq_for_mem)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [80:0] mk(input logic [4:0] op, input logic en,
                                     input logic [3:0] wen, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res,
                                     input logic [31:0] pc);
    return {op, pc, en, wen, |op, we, wa, res};
  endfunction

  function automatic bit m_is_load(input logic [80:0] b);
    return b[43] && (b[80:76] != 5'd0) && (b[42:39] == 4'd0);
  endfunction

  // Load value from the architectural rules: shift the addressed unit down,
  // then sign- or zero-extend according to the opcode.
  function automatic logic [31:0] load_val(input logic [4:0] op, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * o)) & 32'h0000_00FF;
    h = (w >> (16 * o[1])) & 32'h0000_FFFF;
    if (op == OP_LB)  return {{24{b[7]}}, b[7:0]};
    if (op == OP_LBU) return b;
    if (op == OP_LH)  return {{16{h[15]}}, h[15:0]};
    if (op == OP_LHU) return h;
    return w;
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [80:0] m_inst;
  bit          m_got;
  logic [31:0] m_word;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_inst = '0;
      m_got  = 0;
      m_word = '0;
    end else if (stall[3] && !stall[4]) begin
      m_inst = '0;
      m_got  = 0;
    end else if (!stall[3]) begin
      m_inst = ex_to_mem_bus;
      m_got  = 0;
    end else if (m_is_load(m_inst) && !m_got && data_sram_rvalid) begin
      m_got  = 1;
      m_word = data_sram_rdata;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    bit          ld;
    logic [31:0] w;
    logic [31:0] wd;
    logic [69:0] exp_wb;
    if (chk_en) begin
      ld = m_is_load(m_inst);
      w  = (ld && !m_got && data_sram_rvalid) ? data_sram_rdata : m_word;
      wd = ld ? load_val(m_inst[80:76], m_inst[1:0], w) : m_inst[31:0];
      exp_wb = {m_inst[75:44], m_inst[37], m_inst[36:32], wd};
      check("model_wb_bus", mem_to_wb_bus, exp_wb);
      check("model_rf_bus", {32'h0, mem_to_rf_bus}, {32'h0, exp_wb[37:0]});
      check("model_stallreq", {69'h0, stallreq_for_mem},
            {69'h0, ld && !m_got && !data_sram_rvalid});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  // Issue a load; rvalid arrives in MEM cycle 'lat' (1 = first cycle).
  // Before it arrives the bench freezes EX/MEM and MEM/WB like a stall controller.
  task automatic run_load(input string name, input logic [4:0] op, input logic [31:0] addr,
                          input int lat, input logic [31:0] rdata, input logic [31:0] exp);
    ex_to_mem_bus = mk(op, 1'b1, 4'h0, 1'b1, 5'd9, addr, 32'hBFC0_0100);
    stall = 6'b000000;
    data_sram_rvalid = 1'b0;
    step();
    ex_to_mem_bus = mk(5'd0, 1'b0, 4'h0, 1'b1, 5'd3, 32'h0000_0011, 32'hBFC0_0104);
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        stall = 6'b011111;
        data_sram_rvalid = 1'b0;
        data_sram_rdata = $urandom;
      end else begin
        stall = 6'b000000;
        data_sram_rvalid = 1'b1;
        data_sram_rdata = rdata;
      end
      mid();
      check({name, "_stallreq"}, {69'h0, stallreq_for_mem}, {69'h0, (c < lat)});
      if (c == lat) check({name, "_wdata"}, {38'h0, mem_to_wb_bus[31:0]}, {38'h0, exp});
      step();
    end
    data_sram_rvalid = 1'b0;
    stall = 6'b000000;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    chk_en = 0;
    resetn = 1'b0;
    stall = 6'b0;
    ex_to_mem_bus = mk(OP_LW, 1'b1, 4'h0, 1'b1, 5'd1, 32'h1000, 32'h100);
    data_sram_rdata = 32'hFFFF_FFFF;
    data_sram_rvalid = 1'b1;
    repeat (3) @(posedge clk);
    mid();
    check("reset_wb_bus", mem_to_wb_bus, 70'h0);
    check("reset_rf_bus", {32'h0, mem_to_rf_bus}, 70'h0);
    check("reset_stallreq", {69'h0, stallreq_for_mem}, 70'h0);
    step();
    data_sram_rvalid = 1'b0;
    resetn = 1'b1;
    chk_en = 1;

    // lw with data in the first MEM cycle: no stall at all
    run_load("lw_lat1", OP_LW, 32'h1000, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    // byte loads, signed and unsigned, top byte lane
    run_load("lb_1003", OP_LB, 32'h1003, 1, 32'h8012_3456, 32'hFFFF_FF80);
    run_load("lbu_1003", OP_LBU, 32'h1003, 1, 32'h8012_3456, 32'h0000_0080);
    // halfword loads with a 3-cycle response latency
    run_load("lhu_1002", OP_LHU, 32'h1002, 3, 32'hABCD_0000, 32'h0000_ABCD);
    run_load("lh_1002", OP_LH, 32'h1002, 3, 32'hABCD_0000, 32'hFFFF_ABCD);
    run_load("lb_1001", OP_LB, 32'h1001, 2, 32'h0000_7F00, 32'h0000_007F);
    run_load("lh_1001", OP_LH, 32'h1001, 1, 32'h1234_8001, 32'hFFFF_8001);

    // ALU result passes straight through
    ex_to_mem_bus = mk(5'd0, 1'b0, 4'h0, 1'b1, 5'd7, 32'h0000_0055, 32'h200);
    step();
    mid();
    check("alu_rf_bus", {32'h0, mem_to_rf_bus}, {32'h0, 1'b1, 5'd7, 32'h0000_0055});
    check("alu_stallreq", {69'h0, stallreq_for_mem}, 70'h0);

    // store passes through with no stall
    ex_to_mem_bus = mk(5'd0, 1'b1, 4'hF, 1'b0, 5'd0, 32'h0000_2000, 32'h204);
    step();
    mid();
    check("store_wdata", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h0000_2000});
    check("store_stallreq", {69'h0, stallreq_for_mem}, 70'h0);

    // lw answered during an external freeze, held across 4 stalled cycles
    ex_to_mem_bus = mk(OP_LW, 1'b1, 4'h0, 1'b1, 5'd12, 32'h0000_3004, 32'h208);
    step();
    ex_to_mem_bus = mk(5'd0, 1'b0, 4'h0, 1'b1, 5'd4, 32'h0000_0099, 32'h20C);
    stall = 6'b011111;
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    mid();
    check("hold_c1_wdata", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h1234_5678});
    for (int c = 2; c <= 4; c++) begin
      step();
      data_sram_rvalid = (c == 3);
      data_sram_rdata = 32'hFFFF_0000;
      mid();
      check("hold_stall_wdata", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h1234_5678});
      check("hold_stallreq", {69'h0, stallreq_for_mem}, 70'h0);
    end
    step();
    data_sram_rvalid = 1'b0;
    stall = 6'b000000;
    mid();
    check("hold_release_wdata", {38'h0, mem_to_wb_bus[31:0]}, {38'h0, 32'h1234_5678});
    step();

    // bubble: stall[3]=1, stall[4]=0 clears the register
    ex_to_mem_bus = mk(5'd0, 1'b0, 4'h0, 1'b1, 5'd21, 32'hAAAA_5555, 32'h300);
    step();
    stall = 6'b001000;
    step();
    mid();
    check("bubble_wb_bus", mem_to_wb_bus, 70'h0);
    check("bubble_rf_bus", {32'h0, mem_to_rf_bus}, 70'h0);
    stall = 6'b000000;
    step();

    // asynchronous reset in the middle of a wait
    ex_to_mem_bus = mk(OP_LW, 1'b1, 4'h0, 1'b1, 5'd30, 32'h0000_4000, 32'h400);
    step();
    stall = 6'b011111;
    data_sram_rvalid = 1'b0;
    mid();
    check("prereset_stallreq", {69'h0, stallreq_for_mem}, {69'h0, 1'b1});
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_wb_bus", mem_to_wb_bus, 70'h0);
    check("async_reset_rf_bus", {32'h0, mem_to_rf_bus}, 70'h0);
    check("async_reset_stallreq", {69'h0, stallreq_for_mem}, 70'h0);
    step();
    resetn = 1'b1;
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    mid();
    check("stale_rvalid_stallreq", {69'h0, stallreq_for_mem}, 70'h0);
    check("stale_rvalid_wb_bus", mem_to_wb_bus, 70'h0);
    step();
    data_sram_rvalid = 1'b0;
    stall = 6'b000000;
    repeat (3) step();

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
